// File: rtl/pixel_fb_pkg.sv
// Shared defaults and FSM encoding for the pixel framebuffer writer.
package pixel_fb_pkg;

    localparam int unsigned FB_WIDTH_DEF    = 160;
    localparam int unsigned FB_HEIGHT_DEF   = 120;
    localparam int unsigned ADDR_W          = 15;
    localparam int unsigned COLOUR_BITS_DEF = 3;
    localparam logic [23:0] KEY_COLOUR_DEF  = 24'hFF00FF;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WRITE = 1'b1;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO; read data is registered on pop and held until the next pop.
module pixel_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW:0]      count;

    always_comb begin
        full  = (count == (PW+1)'(DEPTH));
        empty = (count == '0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    // Push at full is legal only alongside a pop; the read sees the old entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            rdata <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr  <= rptr + PW'(1);
                rdata <= mem[rptr];
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_fb_writer.sv
// Filters, clips and colour-reduces tile drawer pixels, then writes them to the framebuffer.
module pixel_fb_writer
    import pixel_fb_pkg::*;
#(
    parameter int unsigned FB_WIDTH    = FB_WIDTH_DEF,
    parameter int unsigned FB_HEIGHT   = FB_HEIGHT_DEF,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned COLOUR_BITS = COLOUR_BITS_DEF,
    parameter logic [23:0] KEY_COLOUR  = KEY_COLOUR_DEF
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     vga_draw_enable,
    input  logic [7:0]               vga_x_out,
    input  logic [7:0]               vga_y_out,
    input  logic [23:0]              vga_RGB_out,
    input  logic                     fb_ready,
    input  logic                     clear_status,
    output logic                     fb_we,
    output logic [ADDR_W-1:0]        fb_addr,
    output logic [3*COLOUR_BITS-1:0] fb_data,
    output logic                     busy,
    output logic                     overflow,
    output logic [7:0]               drop_count
);

    localparam int unsigned DW = 3 * COLOUR_BITS;

    logic [ADDR_W-1:0]    pix_addr;
    logic [DW-1:0]        pix_colour;
    logic [ADDR_W+DW-1:0] rdata;
    logic                 clipped;
    logic                 keyed;
    logic                 want_push;
    logic                 push;
    logic                 pop;
    logic                 lost;
    logic                 drop;
    logic                 full;
    logic                 empty;
    logic [0:0]           state_q;
    logic [0:0]           state_d;

    always_comb begin
        clipped    = ({24'd0, vga_x_out} >= FB_WIDTH) || ({24'd0, vga_y_out} >= FB_HEIGHT);
        keyed      = (vga_RGB_out == KEY_COLOUR);
        pix_addr   = ADDR_W'(vga_y_out) * ADDR_W'(FB_WIDTH) + ADDR_W'(vga_x_out);
        pix_colour = {vga_RGB_out[23 -: COLOUR_BITS], vga_RGB_out[15 -: COLOUR_BITS],
                      vga_RGB_out[7 -: COLOUR_BITS]};
        // The FIFO's registered read port doubles as the framebuffer output register.
        pop        = !empty && ((state_q == ST_IDLE) || fb_ready);
        want_push  = vga_draw_enable && !clipped && !keyed;
        push       = want_push && (!full || pop);
        lost       = want_push && !push;
        drop       = vga_draw_enable && (clipped || keyed || lost);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!empty) state_d = ST_WRITE;
            ST_WRITE: if (fb_ready && empty) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            state_q <= state_d;
            if (clear_status) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end else begin
                if (lost) overflow <= 1'b1;
                if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end
        end
    end

    pixel_fifo #(
        .WIDTH (ADDR_W + DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .wdata  ({pix_addr, pix_colour}),
        .pop    (pop),
        .rdata  (rdata),
        .full   (full),
        .empty  (empty)
    );

    always_comb begin
        fb_we   = (state_q == ST_WRITE);
        fb_addr = rdata[ADDR_W+DW-1:DW];
        fb_data = rdata[DW-1:0];
        busy    = !empty || fb_we;
    end

endmodule

// File: doc/pixel_fb_writer.md
# pixel_fb_writer

Receiving end of the tile drawer's pixel output stream. Samples `vga_draw_enable`/`vga_x_out`/`vga_y_out`/`vga_RGB_out` pulses, buffers them in a small FIFO, and clips and transparency-keys them. It then reduces colour depth, computes the linear address, and writes into the framebuffer memory port under a ready/valid stall. It sits between the tile drawer and the VGA adapter's framebuffer.

## Interface
- `FB_WIDTH`, 160, framebuffer width in pixels
- `FB_HEIGHT`, 120, framebuffer height in pixels
- `FIFO_DEPTH`, 8, pixel FIFO entries (power of two, ≥2)
- `COLOUR_BITS`, 3, bits kept per channel (MSBs of each 8-bit channel)
- `KEY_COLOUR`, 24'hFF00FF, transparent colour; matching pixels are dropped
- `clk` in 1 system clock, rising edge
- `resetn` in 1 reset; asynchronous, active-low
- `vga_draw_enable` in 1 one-cycle pixel strobe from the tile drawer
- `vga_x_out` in 8 pixel x
- `vga_y_out` in 8 pixel y
- `vga_RGB_out` in 24 {R,G,B}, 8 bits each
- `fb_ready` in 1 framebuffer accepts the write on the current edge
- `clear_status` in 1 synchronous clear of `overflow` and `drop_count`
- `fb_we` out 1 write valid
- `fb_addr` out 15 y*FB_WIDTH + x
- `fb_data` out 3*COLOUR_BITS {R[7-:CB],G[7-:CB],B[7-:CB]}
- `busy` out 1 FIFO non-empty or `fb_we` high
- `overflow` out 1 sticky: a pixel was lost to a full FIFO
- `drop_count` out 8 saturating count of clipped, keyed, or overflowed pixels

## Operation
- **Input filter.** On each edge with `vga_draw_enable`=1:
  - Drop the pixel if x ≥ FB_WIDTH or y ≥ FB_HEIGHT (clip).
  - Otherwise drop it if RGB == KEY_COLOUR.
  - Otherwise push {addr, reduced colour} into the FIFO.
  - The address is computed before the push. The multiply is by a constant, and the result is 15 bits unsigned.
- **Overflow.**
  - A push is accepted if the FIFO is not full after accounting for a pop on the same edge.
  - Otherwise the pixel is dropped, `overflow` is set, and `drop_count` increments.
- **drop_count.** Increments by 1 per dropped pixel and saturates at 255. `clear_status` has priority over an increment on the same edge.
- **Output FSM.**
  - IDLE: `fb_we`=0. If the FIFO is non-empty, pop, load `fb_addr`/`fb_data`, and go to WRITE.
  - WRITE: `fb_we`=1, with `fb_addr`/`fb_data` held stable. On an edge with `fb_ready`=1: if the FIFO is non-empty, pop and reload while staying in WRITE (back-to-back); otherwise go to IDLE.
- **Ordering.** Writes leave in strict arrival order; no reordering or coalescing.

## Timing
- **Reset values.**
  - Outputs: `fb_we`=0, `fb_addr`=0, `fb_data`=0, `busy`=0, `overflow`=0, `drop_count`=0.
  - Internal: FIFO empty, FSM in IDLE.
- **Latency.** A pixel sampled at edge E0 into an empty block drives `fb_we`=1 after edge E1, i.e. 2 edges from strobe to write visible.
- **Throughput.** With `fb_ready` held at 1, one write per cycle, sustained.
- **Stall.** With `fb_ready`=0, the FIFO absorbs FIFO_DEPTH pixels beyond the one held in the output register. The tile drawer strobes at most every 3rd cycle.
- **Simultaneous push/pop at full.** Push accepted; occupancy unchanged.
- **Reset mid-write.** `fb_we` drops immediately (asynchronously), and FIFO contents are discarded.
- **Boundaries.**
  - x = FB_WIDTH-1, y = FB_HEIGHT-1: written, addr = 19199 at defaults.
  - x = FB_WIDTH: clipped.

## Structure
- **Package `pixel_fb_pkg`.** Holds FB_WIDTH/FB_HEIGHT defaults, the address width (15), the colour-reduction width, KEY_COLOUR, and the FSM state encoding {IDLE, WRITE}.
- **Sub-module `pixel_fifo`.** Synchronous FIFO, parameterised width/depth, with `push`, `pop`, `full`, `empty`, and read-data registered on pop.
- **Top-level contents.** Filter, address calculation, counters, and output FSM.

## Test plan
- **Single pixel.** Reset, `fb_ready`=1. Strobe x=5, y=2, RGB=24'hFF8000 → one `fb_we` pulse 2 edges later, addr=325, data=9'b111_100_000, then `busy`=0.
- **Clip and key.**
  - Strobe x=160, y=0 → no write, `drop_count`=1.
  - Strobe RGB=24'hFF00FF → no write, `drop_count`=2.
- **Stall and drain.** Hold `fb_ready`=0 and strobe 9 pixels every 3 cycles → no overflow. A 10th strobe sets `overflow` and `drop_count`=1. Release `fb_ready` → 9 writes in order on consecutive cycles.
- **Back-to-back.** With `fb_ready` toggling 1,0,1,… over a 4-pixel burst → each address/data held stable while `fb_ready`=0. No loss or duplication.
- **Saturation and clear.** 300 clipped pixels → `drop_count`=255. Then `clear_status` coincident with a drop → `drop_count`=0, `overflow`=0.
- **Reset mid-operation.** Assert `resetn`=0 while in WRITE with 3 pixels queued → `fb_we`=0 immediately. After release, no stale writes occur.
